// File: rtl/serial_byte_loader_if.sv
// Bundles the serial input strobe and the parallel byte handshake of serial_byte_loader.
// The master side feeds bits and consumes bytes; the slave side is the loader itself.
interface serial_byte_loader_if;
  logic       sin;
  logic       sin_valid;
  logic       out_ready;
  logic [7:0] OUT;
  logic       out_valid;
  logic       overrun;
  logic       parity_err;

  modport master (
    output sin, sin_valid, out_ready,
    input  OUT, out_valid, overrun, parity_err
  );

  modport slave (
    input  sin, sin_valid, out_ready,
    output OUT, out_valid, overrun, parity_err
  );
endinterface

// File: rtl/serial_byte_loader.sv
// Serial-to-parallel byte assembler with a registered valid/ready byte output.
// Optional even-parity rejection stage is built when SERIAL_BYTE_LOADER_PARITY_EN is defined.
//
// state   | meaning
// --------+------------------------------------------------------------
// COLLECT | shifting data bits into sh, cnt counts accepted bits
// PARITY  | byte complete in sh, waiting for the even-parity bit
// HOLD    | OUT holds an unconsumed byte, out_valid high
module serial_byte_loader #(
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                  clk,
  input logic                  clear,
  serial_byte_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
    PARITY  = 2'd1,
`endif
    HOLD    = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] out_q, out_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;
  logic [7:0] shifted;
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
  logic       perr_q, perr_d;
`endif

  assign shifted = MSB_FIRST ? {sh_q[6:0], bus.sin} : {bus.sin, sh_q[7:1]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    out_d     = out_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
    perr_d    = 1'b0;
`endif
    case (state_q)
      COLLECT: begin
        if (bus.sin_valid) begin
          sh_d  = shifted;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
            state_d = PARITY;
`else
            out_d   = shifted;
            valid_d = 1'b1;
            state_d = HOLD;
`endif
          end
        end
      end
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
      PARITY: begin
        if (bus.sin_valid) begin
          cnt_d = 3'd0;
          if ((^sh_q ^ bus.sin) == 1'b0) begin
            out_d   = sh_q;
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            perr_d  = 1'b1;
            state_d = COLLECT;
          end
        end
      end
`endif
      HOLD: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = COLLECT;
          // a bit arriving with the handshake starts the next byte
          if (bus.sin_valid) begin
            sh_d  = shifted;
            cnt_d = 3'd1;
          end else begin
            cnt_d = 3'd0;
          end
        end else if (bus.sin_valid) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = COLLECT;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= COLLECT;
      cnt_q     <= 3'd0;
      sh_q      <= 8'h00;
      out_q     <= 8'h00;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign bus.OUT       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.overrun   = overrun_q;
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_byte_loader.sv
// Bench for serial_byte_loader: MSB-first and LSB-first instances share one stimulus
// stream and are checked against a bit-queue reference model.
module tb_serial_byte_loader;

  logic clk = 1'b0;
  logic clear = 1'b1;
  always #5 clk = ~clk;

  serial_byte_loader_if bm ();
  serial_byte_loader_if bl ();

  serial_byte_loader #(.MSB_FIRST(1'b1)) dut_m (.clk(clk), .clear(clear), .bus(bm.slave));
  serial_byte_loader #(.MSB_FIRST(1'b0)) dut_l (.clk(clk), .clear(clear), .bus(bl.slave));

`ifdef SERIAL_BYTE_LOADER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  int vec = 0;
  int bad = 0;

  bit         q[$];
  logic [7:0] e_out_m = 8'h00;
  logic [7:0] e_out_l = 8'h00;
  logic       e_valid = 1'b0;
  logic       e_ovr   = 1'b0;
  logic       e_perr  = 1'b0;

  wire [10:0] stat_m = {bm.OUT, bm.out_valid, bm.overrun, bm.parity_err};
  wire [10:0] stat_l = {bl.OUT, bl.out_valid, bl.overrun, bl.parity_err};

  function automatic logic [10:0] exp_m();
    return {e_out_m, e_valid, e_ovr, e_perr};
  endfunction

  function automatic logic [10:0] exp_l();
    return {e_out_l, e_valid, e_ovr, e_perr};
  endfunction

  // Reference: a byte is just the first 8 queued bits; parity is the XOR of all 9.
  task automatic model(input logic c, input logic sv, input logic s, input logic rdy);
    bit par;
    e_perr = 1'b0;
    if (c) begin
      q.delete();
      e_out_m = 8'h00;
      e_out_l = 8'h00;
      e_valid = 1'b0;
      e_ovr   = 1'b0;
    end else if (e_valid) begin
      if (rdy) begin
        e_valid = 1'b0;
        if (sv) q.push_back(s);
      end else if (sv) begin
        e_ovr = 1'b1;
      end
    end else if (sv) begin
      q.push_back(s);
      if (q.size() == NB) begin
        par = 1'b0;
        foreach (q[i]) par ^= q[i];
        if (NB == 8 || par == 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            e_out_m[7-i] = q[i];
            e_out_l[i]   = q[i];
          end
          e_valid = 1'b1;
        end else begin
          e_perr = 1'b1;
        end
        q.delete();
      end
    end
  endtask

  task automatic step(input logic c, input logic sv, input logic s, input logic rdy);
    @(negedge clk);
    clear        = c;
    bm.sin_valid = sv;  bl.sin_valid = sv;
    bm.sin       = s;   bl.sin       = s;
    bm.out_ready = rdy; bl.out_ready = rdy;
    @(posedge clk);
    model(c, sv, s, rdy);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic p);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, b[7-i], 1'b0);
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
    step(1'b0, 1'b1, p, 1'b0);
`else
    if (p !== ^b) $display("note: parity bit ignored in this build");
`endif
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    vec++;
    if (stat_m !== 11'h000) begin bad++; $display("FAIL reset_m: got %h want %h", stat_m, 11'h000); end
    vec++;
    if (stat_l !== 11'h000) begin bad++; $display("FAIL reset_l: got %h want %h", stat_l, 11'h000); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    vec++;
    if (stat_m !== 11'h000) begin bad++; $display("FAIL reset_release: got %h want %h", stat_m, 11'h000); end
  endtask

  task automatic test_basic_byte();
    send_byte(8'hAA, 1'b0);
    vec++;
    if (bm.OUT !== 8'hAA || bm.out_valid !== 1'b1) begin
      bad++; $display("FAIL basic_byte: got %h/%b want aa/1", bm.OUT, bm.out_valid);
    end
    vec++;
    if (stat_l !== exp_l()) begin bad++; $display("FAIL basic_byte_l: got %h want %h", stat_l, exp_l()); end
    repeat (3) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      vec++;
      if (stat_m !== exp_m()) begin bad++; $display("FAIL basic_hold: got %h want %h", stat_m, exp_m()); end
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    vec++;
    if (bm.OUT !== 8'hAA || bm.out_valid !== 1'b0) begin
      bad++; $display("FAIL basic_ack: got %h/%b want aa/0", bm.OUT, bm.out_valid);
    end
  endtask

  task automatic test_bit_order();
    logic [7:0] bits;
    bits = 8'b0010_0000;
    for (int i = 0; i < NB; i++) begin
      step(1'b0, 1'b1, (i < 8) ? bits[7-i] : 1'b1, 1'b0);
      repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 1'($urandom), 1'b0);
    end
    vec++;
    if (bl.OUT !== 8'h04 || bl.out_valid !== 1'b1) begin
      bad++; $display("FAIL bit_order_l: got %h/%b want 04/1", bl.OUT, bl.out_valid);
    end
    vec++;
    if (stat_m !== exp_m()) begin bad++; $display("FAIL bit_order_m: got %h want %h", stat_m, exp_m()); end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_overrun();
    send_byte(8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    vec++;
    if (bm.overrun !== 1'b1 || bm.OUT !== 8'h00 || bm.out_valid !== 1'b1) begin
      bad++; $display("FAIL overrun: got ovr=%b out=%h v=%b want 1/00/1", bm.overrun, bm.OUT, bm.out_valid);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1);
    vec++;
    if (stat_m !== exp_m()) begin bad++; $display("FAIL overrun_ack: got %h want %h", stat_m, exp_m()); end
    repeat (7) step(1'b0, 1'b1, 1'b1, 1'b0);
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
    step(1'b0, 1'b1, 1'b0, 1'b0);
`endif
    vec++;
    if (bm.OUT !== 8'hFF || bl.OUT !== 8'hFF || bm.overrun !== 1'b1) begin
      bad++; $display("FAIL overrun_ff: got %h/%h ovr=%b want ff/ff/1", bm.OUT, bl.OUT, bm.overrun);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_mid_clear();
    repeat (5) step(1'b0, 1'b1, 1'($urandom), 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    vec++;
    if (stat_m !== 11'h000) begin bad++; $display("FAIL mid_clear: got %h want %h", stat_m, 11'h000); end
    send_byte(8'h0F, 1'b0);
    vec++;
    if (bm.OUT !== 8'h0F || bm.out_valid !== 1'b1) begin
      bad++; $display("FAIL mid_clear_byte: got %h/%b want 0f/1", bm.OUT, bm.out_valid);
    end
    vec++;
    if (stat_l !== exp_l()) begin bad++; $display("FAIL mid_clear_l: got %h want %h", stat_l, exp_l()); end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

`ifdef SERIAL_BYTE_LOADER_PARITY_EN
  task automatic test_parity();
    send_byte(8'hAA, 1'b0);
    vec++;
    if (bm.OUT !== 8'hAA || bm.out_valid !== 1'b1 || bm.parity_err !== 1'b0) begin
      bad++; $display("FAIL parity_good: got %h/%b/%b want aa/1/0", bm.OUT, bm.out_valid, bm.parity_err);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_byte(8'hAA, 1'b1);
    vec++;
    if (bm.parity_err !== 1'b1 || bm.out_valid !== 1'b0 || bm.OUT !== 8'hAA) begin
      bad++; $display("FAIL parity_bad: got perr=%b v=%b out=%h want 1/0/aa", bm.parity_err, bm.out_valid, bm.OUT);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    vec++;
    if (bm.parity_err !== 1'b0 || bl.parity_err !== 1'b0) begin
      bad++; $display("FAIL parity_pulse: got %b/%b want 0/0", bm.parity_err, bl.parity_err);
    end
    send_byte(8'h3C, 1'b0);
    vec++;
    if (bm.OUT !== 8'h3C || bm.out_valid !== 1'b1) begin
      bad++; $display("FAIL parity_recover: got %h/%b want 3c/1", bm.OUT, bm.out_valid);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask
`endif

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 4 * NB; i++) begin
      step(1'b0, 1'b1, 1'($urandom), 1'b1);
      if (bm.out_valid === 1'b1) pulses++;
      vec++;
      if (stat_m !== exp_m() || stat_l !== exp_l()) begin
        bad++; $display("FAIL back_to_back: got %h/%h want %h/%h", stat_m, stat_l, exp_m(), exp_l());
      end
    end
    vec++;
    if (pulses !== 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", pulses); end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom), 1'($urandom_range(0, 2) == 0));
      vec++;
      if (stat_m !== exp_m()) begin bad++; $display("FAIL random_m: got %h want %h", stat_m, exp_m()); end
      vec++;
      if (stat_l !== exp_l()) begin bad++; $display("FAIL random_l: got %h want %h", stat_l, exp_l()); end
    end
  endtask

  initial begin
    bm.sin = 1'b0; bm.sin_valid = 1'b0; bm.out_ready = 1'b0;
    bl.sin = 1'b0; bl.sin_valid = 1'b0; bl.out_ready = 1'b0;
    test_reset();
    test_basic_byte();
    test_bit_order();
    test_overrun();
    test_mid_clear();
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/serial_byte_loader.md
# serial_byte_loader

- Serial-to-parallel front end that assembles an 8-bit byte from a bit stream qualified by a valid strobe.
- Presents the byte on a registered parallel output with a valid/ready handshake.
- Sits directly upstream of the 8-bit clearable data register: `OUT` drives the register's `IN`, and the register loads when `out_valid && out_ready`.
- An optional parity stage rejects corrupted bytes before they reach the register.

## Interface
- `MSB_FIRST`, default 1: 1 means the first accepted bit lands in `OUT[7]`; 0 means it lands in `OUT[0]`.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `clear`  in  1  reset, synchronous, active-high.
- `sin`  in  1  serial data bit.
- `sin_valid`  in  1  `sin` is sampled on this edge when high.
- `out_ready`  in  1  downstream accepts the byte.
- `OUT`  out  8  assembled byte (registered).
- `out_valid`  out  1  `OUT` holds a new, unconsumed byte.
- `overrun`  out  1  sticky; a bit arrived while a byte was pending and was dropped.
- `parity_err`  out  1  one-cycle pulse; a byte failed the parity check and was discarded.

## Operation
- There are three states: COLLECT, PARITY and HOLD. PARITY is present only with `PARITY_EN`.
- The design keeps a 3-bit counter `cnt` and an 8-bit shift register `sh`.
- **COLLECT**
  - Each cycle with `sin_valid=1`, shift `sin` into `sh` and increment `cnt`.
  - With `MSB_FIRST=1`, bits shift left and enter at bit 0. With `MSB_FIRST=0`, bits shift right and enter at bit 7.
  - On the 8th bit (`cnt==7`, wrapping to 0):
    - Without `PARITY_EN`: load `OUT` with the completed byte, set `out_valid`, go to HOLD.
    - With `PARITY_EN`: keep the byte in `sh` and go to PARITY.
- **PARITY** (`PARITY_EN` only)
  - Wait for the next `sin_valid` and treat that bit as an even-parity bit.
  - If the XOR of the 8 data bits and the parity bit is 0: load `OUT` from `sh`, set `out_valid`, go to HOLD.
  - Otherwise: pulse `parity_err` for one cycle, leave `OUT` unchanged, go to COLLECT with `cnt=0`.
- **HOLD**
  - `out_valid=1` and `OUT` is stable.
  - On `out_ready=1`: clear `out_valid` and go to COLLECT.
  - If `sin_valid=1` in the same cycle as `out_ready=1`, that bit is accepted as bit 1 of the next byte, so COLLECT is entered with `cnt=1`.
  - If `sin_valid=1` while `out_ready=0`, the bit is dropped and `overrun` is set.
- `OUT` keeps its last loaded value after the handshake; it is never cleared except by `clear`.
- `overrun` stays set until `clear`. Nothing else clears it.
- `clear` takes priority over every other input, including in mid-byte, mid-parity and HOLD:
  - state goes to COLLECT, `cnt=0`, `sh=0`;
  - the partial byte is discarded.

## Timing
- Reset values: `OUT=8'h00`, `out_valid=0`, `overrun=0`, `parity_err=0`, state COLLECT, `cnt=0`.
- Latency without parity: if the 8th bit is sampled at edge N, `OUT` and `out_valid` are valid after edge N.
- Latency with `PARITY_EN`: the same, with N being the edge that samples the parity bit.
- `out_valid` falls after the edge on which `out_ready=1` was sampled.
- `out_ready` is ignored when `out_valid=0`.
- Maximum throughput is one byte per 8 `sin_valid` cycles (9 with parity), provided the consumer holds `out_ready=1`.
- `parity_err` is high for exactly the one cycle following the edge that sampled the bad parity bit.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- The macro is `SERIAL_BYTE_LOADER_PARITY_EN`.
- **Defined:** the PARITY state exists, and each byte consumes 9 serial bits (8 data bits plus 1 even-parity bit).
- **Undefined:**
  - the PARITY state is not built;
  - each byte consumes 8 bits;
  - `parity_err` is tied to 0;
  - all other behaviour is identical.

## Test plan
- **Reset:** assert `clear` for 2 cycles with `sin_valid` toggling. Required: all outputs equal 0 and no byte is produced.
- **Basic byte:** `MSB_FIRST=1`, feed bits 1,0,1,0,1,0,1,0 on consecutive cycles, `out_ready=0`. Required: `OUT=8'hAA` and `out_valid=1` after the 8th edge; both held until `out_ready=1`, then `out_valid` goes to 0 while `OUT` stays `8'hAA`.
- **Bit order and gaps:** `MSB_FIRST=0`, feed 0,0,1,0,0,0,0,0 with idle cycles (`sin_valid=0`) between bits. Required: `OUT=8'h04`.
- **Overrun and simultaneous events:**
  - In HOLD with `out_ready=0`, pulse `sin_valid`. Required: `overrun=1` and `OUT` unchanged.
  - Then assert `out_ready` and `sin_valid` together, followed by 7 more bits forming `8'hFF`. Required: `OUT=8'hFF`.
- **Mid-byte clear:** after 5 bits, assert `clear` for 1 cycle, then send `8'h0F`. Required: `OUT=8'h0F`, with no contamination from the partial byte.
- **Parity (macro defined):**
  - Send `8'hAA` followed by parity bit 0. Required: byte delivered.
  - Send `8'hAA` followed by parity bit 1. Required: `parity_err` pulses for 1 cycle, `out_valid` stays 0, and `OUT` still holds the previous value.
